// File: rtl/fpu_pkg.sv
// Shared FPU definitions: bfloat16 field layout, status flag encodings and
// the integer-to-float converter state type.
package fpu_pkg;

  localparam int BF16_BIAS  = 127;
  localparam int BF16_EXP_W = 8;
  localparam int BF16_MAN_W = 7;
  localparam int BF16_W     = 1 + BF16_EXP_W + BF16_MAN_W;

  localparam logic [2:0] FLAG_NONE    = 3'b000;
  localparam logic [2:0] FLAG_OVF     = 3'b001;
  localparam logic [2:0] FLAG_UNF     = 3'b010;
  localparam logic [2:0] FLAG_INEXACT = 3'b100;

  typedef enum logic [1:0] {
    IDLE,
    NORM,
    DONE
  } i2f_state_e;

endpackage

// File: rtl/bf16_round_rne.sv
// Round-to-nearest-even for a normalised bfloat16 significand. A carry out of
// an all-ones significand wraps it to zero and bumps the exponent by one.
module bf16_round_rne
  import fpu_pkg::*;
(
  input  logic [BF16_MAN_W-1:0] sig,
  input  logic                  guard,
  input  logic                  sticky,
  input  logic [BF16_EXP_W-1:0] exp,
  output logic [BF16_MAN_W-1:0] sig_rnd,
  output logic [BF16_EXP_W-1:0] exp_rnd,
  output logic                  inexact
);

  logic round_up;

  // Round up only above the halfway point, or exactly at it when the kept LSB is odd.
  always_comb begin
    round_up = guard && (sticky || sig[0]);
    sig_rnd  = sig;
    exp_rnd  = exp;
    inexact  = guard | sticky;
    if (round_up) begin
      if (sig == '1) begin
        sig_rnd = '0;
        exp_rnd = exp + 8'd1;
      end else begin
        sig_rnd = sig + 7'd1;
      end
    end
  end

endmodule

// File: rtl/int_to_fp.sv
// Iterative 32-bit sign-magnitude integer to bfloat16 converter. The magnitude
// is left-normalised in coarse then single-bit steps, one step per cycle, and
// the result is rounded to nearest-even. One conversion in flight at a time.
module int_to_fp
  import fpu_pkg::*;
#(
  parameter int COARSE_SHIFT = 8
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [31:0] int_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [15:0] fp_o,
  output logic [2:0]  flag
);

  // Exponent of a magnitude whose leading one already sits at bit 30.
  localparam logic [7:0] EXP_START = 8'(BF16_BIAS + 30);

  i2f_state_e state_q, state_d;
  logic        sign_q, sign_d;
  logic [30:0] mag_q, mag_d;
  logic [7:0]  exp_q, exp_d;
  logic [15:0] fp_q, fp_d;
  logic [2:0]  flag_q, flag_d;

  logic [6:0]  sig_rnd;
  logic [7:0]  exp_rnd;
  logic        inexact;

  bf16_round_rne u_round (
    .sig     (mag_q[29:23]),
    .guard   (mag_q[22]),
    .sticky  (|mag_q[21:0]),
    .exp     (exp_q),
    .sig_rnd (sig_rnd),
    .exp_rnd (exp_rnd),
    .inexact (inexact)
  );

  // Conversion state and result registers; reset discards any conversion in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      sign_q  <= 1'b0;
      mag_q   <= '0;
      exp_q   <= '0;
      fp_q    <= '0;
      flag_q  <= FLAG_NONE;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      mag_q   <= mag_d;
      exp_q   <= exp_d;
      fp_q    <= fp_d;
      flag_q  <= flag_d;
    end
  end

  // Accept in IDLE, normalise one step per cycle in NORM, hold the result in DONE until taken.
  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    mag_d   = mag_q;
    exp_d   = exp_q;
    fp_d    = fp_q;
    flag_d  = flag_q;
    case (state_q)
      IDLE: begin
        if (valid_i) begin
          sign_d = int_i[31];
          mag_d  = int_i[30:0];
          exp_d  = EXP_START;
          if (int_i[30:0] == '0) begin
            fp_d    = {int_i[31], 15'b0};
            flag_d  = FLAG_NONE;
            state_d = DONE;
          end else begin
            state_d = NORM;
          end
        end
      end
      NORM: begin
        if (mag_q[30 -: COARSE_SHIFT] == '0) begin
          mag_d = mag_q << COARSE_SHIFT;
          exp_d = exp_q - 8'(COARSE_SHIFT);
        end else if (!mag_q[30]) begin
          mag_d = mag_q << 1;
          exp_d = exp_q - 8'd1;
        end else begin
          fp_d    = {sign_q, exp_rnd, sig_rnd};
          flag_d  = inexact ? FLAG_INEXACT : FLAG_NONE;
          state_d = DONE;
        end
      end
      DONE: begin
        if (ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ready_o = (state_q == IDLE);
  assign valid_o = (state_q == DONE);
  assign fp_o    = fp_q;
  assign flag    = flag_q;

endmodule

// File: tb/tb_int_to_fp.sv
// Bench for int_to_fp: a reference model pushes expected results into a
// scoreboard when a conversion is accepted; results are popped and compared
// when valid_o rises.
module tb_int_to_fp;

  typedef struct {
    logic [15:0] fp;
    logic [2:0]  flg;
    int          lat;
  } expect_t;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        valid_i;
  logic        ready_o;
  logic [31:0] int_i;
  logic        valid_o;
  logic        ready_i;
  logic [15:0] fp_o;
  logic [2:0]  flag;

  expect_t sb[$];
  int checks = 0;
  int fails  = 0;

  int_to_fp dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .int_i   (int_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .fp_o    (fp_o),
    .flag    (flag)
  );

  // Free-running clock.
  always #5 clk_i = ~clk_i;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // Reference: locate the leading one, slice out significand/guard/sticky, round to nearest-even.
  function automatic expect_t model(input logic [31:0] v);
    expect_t     r;
    logic [30:0] mag;
    logic [31:0] rest;
    logic [8:0]  full;
    logic [6:0]  sig;
    logic        g, s;
    int          p, e, lz;
    mag = v[30:0];
    if (mag == 31'd0) begin
      r.fp  = {v[31], 15'b0};
      r.flg = 3'b000;
      r.lat = 1;
      return r;
    end
    p = 30;
    while (!mag[p]) p--;
    e = 127 + p;
    if (p <= 7) begin
      rest = {1'b0, mag} << (7 - p);
      sig  = rest[6:0];
      g    = 1'b0;
      s    = 1'b0;
    end else begin
      rest = {1'b0, mag} >> (p - 7);
      sig  = rest[6:0];
      g    = mag[p-8];
      rest = ({1'b0, mag} << (40 - p)) & 32'hFFFF_FFFF;
      s    = ({1'b0, mag} & ((32'd1 << (p - 8)) - 32'd1)) != 32'd0;
    end
    full = {2'b01, sig} + ((g && (s || sig[0])) ? 9'd1 : 9'd0);
    if (full[8]) begin
      e   = e + 1;
      sig = 7'd0;
    end else begin
      sig = full[6:0];
    end
    r.fp  = {v[31], 8'(e), sig};
    r.flg = (g || s) ? 3'b100 : 3'b000;
    lz    = 30 - p;
    r.lat = 2 + lz / 8 + lz % 8;
    return r;
  endfunction

  // Drive one conversion, measure latency, compare against the scoreboard, then
  // hold the result for 'hold' cycles of backpressure before taking it.
  task automatic apply_stimulus(input logic [31:0] val, input int hold);
    expect_t     e;
    int          lat;
    logic [15:0] held_fp;
    logic [2:0]  held_flag;
    check_output($sformatf("ready_before_%08h", val), 32'(ready_o), 32'd1);
    valid_i = 1'b1;
    int_i   = val;
    sb.push_back(model(val));
    @(posedge clk_i);
    #1;
    valid_i = 1'b0;
    int_i   = $urandom;
    lat = 1;
    while (!valid_o && lat < 60) begin
      @(posedge clk_i);
      #1;
      lat++;
    end
    e = sb.pop_front();
    if (!valid_o) begin
      check_output($sformatf("timeout_%08h", val), 32'(valid_o), 32'd1);
      return;
    end
    check_output($sformatf("fp_%08h", val), 32'(fp_o), 32'(e.fp));
    check_output($sformatf("flag_%08h", val), 32'(flag), 32'(e.flg));
    check_output($sformatf("latency_%08h", val), 32'(lat), 32'(e.lat));
    held_fp   = fp_o;
    held_flag = flag;
    for (int i = 0; i < hold; i++) begin
      valid_i = i[0];
      int_i   = $urandom;
      @(posedge clk_i);
      #1;
      check_output("bp_valid", 32'(valid_o), 32'd1);
      check_output("bp_ready", 32'(ready_o), 32'd0);
      check_output("bp_fp", 32'(fp_o), 32'(held_fp));
      check_output("bp_flag", 32'(flag), 32'(held_flag));
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    ready_i = 1'b0;
    check_output("post_valid", 32'(valid_o), 32'd0);
    check_output("post_ready", 32'(ready_o), 32'd1);
  endtask

  // Directed cases, backpressure, reset mid-conversion, then random inputs.
  initial begin
    logic [31:0] v;
    rst_ni  = 1'b0;
    valid_i = 1'b0;
    ready_i = 1'b0;
    int_i   = '0;
    #12;
    check_output("rst_valid", 32'(valid_o), 32'd0);
    check_output("rst_ready", 32'(ready_o), 32'd1);
    check_output("rst_fp", 32'(fp_o), 32'h0);
    check_output("rst_flag", 32'(flag), 32'h0);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;

    apply_stimulus(32'h0000_0001, 0);
    check_output("ref_one", 32'(model(32'h0000_0001).fp), 32'h3F80);
    apply_stimulus(32'h8000_0003, 0);
    apply_stimulus(32'h0000_0000, 0);
    apply_stimulus(32'h8000_0000, 0);
    apply_stimulus(32'd514, 0);
    apply_stimulus(32'd518, 0);
    apply_stimulus(32'd257, 0);
    apply_stimulus(32'h7FFF_FFFF, 0);
    apply_stimulus(32'h4000_0000, 0);
    apply_stimulus(32'h0000_1234, 5);

    valid_i = 1'b1;
    int_i   = 32'h0000_0001;
    @(posedge clk_i);
    #1;
    valid_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #3;
    rst_ni = 1'b0;
    #1;
    check_output("midrst_valid", 32'(valid_o), 32'd0);
    check_output("midrst_ready", 32'(ready_o), 32'd1);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    check_output("midrst_idle_valid", 32'(valid_o), 32'd0);
    apply_stimulus(32'h0000_0003, 0);

    for (int i = 0; i < 24; i++) begin
      v = $urandom >> $urandom_range(0, 31);
      apply_stimulus(v, $urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  // Absolute time limit so a stuck handshake still ends the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
